// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite layer renderer: screen geometry,
// the per-slot record and the colour slices taken from sprite memory.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 800;
  localparam int unsigned SCREEN_H = 600;
  localparam int unsigned RASTER_W = 11;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned ELEM_W   = 3;
  localparam int unsigned SEL_W    = 3;

  // 3-bit VGA channels use the upper three bits of each 4-bit memory channel
  localparam int unsigned CH_W  = 3;
  localparam int unsigned R_LSB = 9;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_LSB = 1;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ELEM_W-1:0]  element;
    logic               en;
    logic               mirror;
  } slot_t;

endpackage

// File: rtl/sprite_layer_renderer_if.sv
// Slot configuration write port and sprite-memory read port of the renderer.
interface sprite_layer_renderer_if #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned COLOR_W = 12
);
  import sprite_pkg::*;

  logic               cfg_we;
  logic [SEL_W-1:0]   cfg_sel;
  logic [COORD_W-1:0] cfg_x;
  logic [COORD_W-1:0] cfg_y;
  logic [ELEM_W-1:0]  cfg_element;
  logic               cfg_en;
  logic               cfg_mirror;

  logic [ADDR_W-1:0]  mem_addr;
  logic [ELEM_W-1:0]  mem_element;
  logic [COLOR_W-1:0] mem_data;

  modport master (
    output cfg_we, cfg_sel, cfg_x, cfg_y, cfg_element, cfg_en, cfg_mirror,
    input  mem_addr, mem_element,
    output mem_data
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_x, cfg_y, cfg_element, cfg_en, cfg_mirror,
    output mem_addr, mem_element,
    input  mem_data
  );

endinterface

// File: rtl/sprite_hit_unit.sv
// Per-slot raster hit test and sprite-relative offsets (combinational).
// SPRITE_MIRROR_EN: when defined, mirror=1 flips the horizontal offset.
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter  int unsigned SPRITE_SIZE = 32,
  localparam int unsigned LOG_SZ      = $clog2(SPRITE_SIZE)
) (
  input  slot_t                slot,
  input  logic [RASTER_W-1:0]  pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  output logic                 hit_c,
  output logic [LOG_SZ-1:0]    dx_c,
  output logic [LOG_SZ-1:0]    dy_c
);

  logic [RASTER_W-1:0] sx, sy, py, lim_x, lim_y;
  logic [LOG_SZ-1:0]   dx_raw;

  // 11-bit compare: sprites past the right/bottom edge clip instead of wrapping
  always_comb begin
    sx     = RASTER_W'(slot.x);
    sy     = RASTER_W'(slot.y);
    py     = RASTER_W'(pixel_y);
    lim_x  = sx + RASTER_W'(SPRITE_SIZE);
    lim_y  = sy + RASTER_W'(SPRITE_SIZE);
    hit_c  = slot.en
             && (pixel_x >= sx) && (pixel_x < lim_x)
             && (py >= sy) && (py < lim_y)
             && (pixel_x < RASTER_W'(SCREEN_W)) && (py < RASTER_W'(SCREEN_H));
    dx_raw = LOG_SZ'(pixel_x - sx);
    dy_c   = LOG_SZ'(py - sy);
`ifdef SPRITE_MIRROR_EN
    dx_c   = slot.mirror ? ~dx_raw : dx_raw;
`else
    dx_c   = dx_raw;
`endif
  end

`ifndef SPRITE_MIRROR_EN
  logic unused_mirror;
  assign unused_mirror = slot.mirror;
`endif

endmodule

// File: rtl/sprite_layer_renderer.sv
// Hardware sprite layer: double-buffered slot registers, priority fetch and a
// 3-cycle raster-to-VGA pipeline. SPRITE_MIRROR_EN enables horizontal mirroring.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPRITES   = 4,
  parameter int unsigned SPRITE_SIZE = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned COLOR_W     = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_enable,
  input  logic [RASTER_W-1:0]       pixel_x,
  input  logic [COORD_W-1:0]        pixel_y,
  input  logic                      frame_sync,
  input  logic                      coll_clear,
  sprite_layer_renderer_if.slave    bus,
  output logic [N_SPRITES-1:0]      collision,
  output logic [CH_W-1:0]           VGA_R,
  output logic [CH_W-1:0]           VGA_G,
  output logic [CH_W-1:0]           VGA_B
);

  localparam int unsigned LOG_SZ = $clog2(SPRITE_SIZE);

  slot_t shadow_q [N_SPRITES];
  slot_t shadow_d [N_SPRITES];
  slot_t active_q [N_SPRITES];
  slot_t active_d [N_SPRITES];
  slot_t cfg_slot_c;

  logic [N_SPRITES-1:0] hit_c;
  logic [LOG_SZ-1:0]    dx_c [N_SPRITES];
  logic [LOG_SZ-1:0]    dy_c [N_SPRITES];

  logic                 win_hit_c;
  logic [ELEM_W-1:0]    win_el_c;
  logic [LOG_SZ-1:0]    win_dx_c, win_dy_c;
  logic [N_SPRITES-1:0] coll_set_c;
  logic                 vga_on_c;

  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [ELEM_W-1:0]    mem_element_q, mem_element_d;
  logic                 s0_hit_q, s0_hit_d, s0_ven_q, s0_ven_d;
  logic                 s1_hit_q, s1_hit_d, s1_ven_q, s1_ven_d;
  logic [CH_W-1:0]      vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic [N_SPRITES-1:0] collision_q, collision_d;
  logic                 unused_c;

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_slot
    sprite_hit_unit #(.SPRITE_SIZE(SPRITE_SIZE)) u_hit (
      .slot    (active_q[g]),
      .pixel_x (pixel_x),
      .pixel_y (pixel_y),
      .hit_c   (hit_c[g]),
      .dx_c    (dx_c[g]),
      .dy_c    (dy_c[g])
    );
  end

  always_comb begin
    cfg_slot_c         = '0;
    cfg_slot_c.x       = bus.cfg_x;
    cfg_slot_c.y       = bus.cfg_y;
    cfg_slot_c.element = bus.cfg_element;
    cfg_slot_c.en      = bus.cfg_en;
`ifdef SPRITE_MIRROR_EN
    cfg_slot_c.mirror  = bus.cfg_mirror;
`else
    cfg_slot_c.mirror  = 1'b0;
`endif
  end

  // Writes land in the shadow copy; frame_sync promotes it (same-cycle write included)
  always_comb begin
    for (int i = 0; i < N_SPRITES; i++) begin
      shadow_d[i] = shadow_q[i];
      if (bus.cfg_we && (bus.cfg_sel == SEL_W'(i))) shadow_d[i] = cfg_slot_c;
      active_d[i] = frame_sync ? shadow_d[i] : active_q[i];
    end
  end

  // Lowest hitting index owns the fetch
  always_comb begin
    win_hit_c = 1'b0;
    win_el_c  = '0;
    win_dx_c  = '0;
    win_dy_c  = '0;
    for (int i = int'(N_SPRITES) - 1; i >= 0; i--) begin
      if (hit_c[i]) begin
        win_hit_c = 1'b1;
        win_el_c  = active_q[i].element;
        win_dx_c  = dx_c[i];
        win_dy_c  = dy_c[i];
      end
    end
    coll_set_c = (video_enable && ($countones(hit_c) > 1)) ? hit_c : '0;
  end

  always_comb begin
    mem_addr_d    = win_hit_c ? ADDR_W'({win_dy_c, win_dx_c}) : '0;
    mem_element_d = win_hit_c ? win_el_c : '0;
    s0_hit_d      = win_hit_c;
    s0_ven_d      = video_enable;
    s1_hit_d      = s0_hit_q;
    s1_ven_d      = s0_ven_q;
    vga_on_c      = s1_hit_q && s1_ven_q;
    vga_r_d       = vga_on_c ? bus.mem_data[R_LSB +: CH_W] : '0;
    vga_g_d       = vga_on_c ? bus.mem_data[G_LSB +: CH_W] : '0;
    vga_b_d       = vga_on_c ? bus.mem_data[B_LSB +: CH_W] : '0;
    // a set in the same cycle as a clear survives
    collision_d   = (coll_clear ? '0 : collision_q) | coll_set_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      mem_addr_q    <= '0;
      mem_element_q <= '0;
      s0_hit_q      <= 1'b0;
      s0_ven_q      <= 1'b0;
      s1_hit_q      <= 1'b0;
      s1_ven_q      <= 1'b0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      collision_q   <= '0;
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      mem_addr_q    <= mem_addr_d;
      mem_element_q <= mem_element_d;
      s0_hit_q      <= s0_hit_d;
      s0_ven_q      <= s0_ven_d;
      s1_hit_q      <= s1_hit_d;
      s1_ven_q      <= s1_ven_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      collision_q   <= collision_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_element = mem_element_q;
  assign VGA_R           = vga_r_q;
  assign VGA_G           = vga_g_q;
  assign VGA_B           = vga_b_q;
  assign collision       = collision_q;

  // Only the upper three bits of each memory channel reach the DAC
  assign unused_c = ^{bus.mem_data, bus.cfg_mirror};

endmodule

// File: doc/sprite_layer_renderer.md
SPRITE_LAYER_RENDERER -- requirements
Module: sprite_layer_renderer

Interface
REQ-001 Parameter N_SPRITES, default 4: number of independent sprite slots (1..8).
REQ-002 Parameter SPRITE_SIZE, default 32: sprite edge length in pixels, power of two, 8..128.
REQ-003 Parameter ADDR_W, default 12: sprite-memory address width; must satisfy 2^ADDR_W >= SPRITE_SIZE*SPRITE_SIZE.
REQ-004 Parameter COLOR_W, default 12: memory pixel width, 4 bits per channel.
REQ-005 clk  in  1: single clock (50 MHz pixel domain); all logic is clocked on its rising edge.
REQ-006 reset  in  1: asynchronous, active-low reset.
REQ-007 video_enable  in  1: active-display indicator from SVGA_sync.
REQ-008 pixel_x  in  11 / pixel_y  in  10: current raster coordinates from SVGA_sync.
REQ-009 frame_sync  in  1: one-cycle pulse at frame start (vertical blank).
REQ-010 cfg_we  in  1 / cfg_sel  in  3 / cfg_x  in  10 / cfg_y  in  10 / cfg_element  in  3 / cfg_en  in  1 / cfg_mirror  in  1: slot write port.
REQ-011 mem_addr  out  ADDR_W / mem_element  out  3: sprite-memory read request.
REQ-012 mem_data  in  COLOR_W: read data, valid exactly 1 cycle after the request.
REQ-013 VGA_R / VGA_G / VGA_B  out  3 each: colour output, taken from bits [11:9], [7:5] and [3:1].
REQ-014 collision  out  N_SPRITES / coll_clear  in  1: sticky per-slot overlap flags and their clear strobe.

Function
REQ-015 On cfg_we with cfg_sel < N_SPRITES, the slot's shadow registers SHALL load the cfg_* fields; writes with cfg_sel >= N_SPRITES SHALL be ignored.
REQ-016 On frame_sync, every slot's active registers SHALL copy its shadow registers; if cfg_we coincides, the written value SHALL reach the active registers directly.
REQ-017 A slot hits when en=1 && x <= pixel_x < x+SPRITE_SIZE && y <= pixel_y < y+SPRITE_SIZE; the comparison is 11-bit so no wrap occurs; sprites crossing x=799 or y=599 are clipped.
REQ-018 When several slots hit, the lowest index wins the memory fetch.
REQ-019 Stage 0 registers mem_addr = dy*SPRITE_SIZE + dx and mem_element = winner.element (dx, dy relative to the sprite origin); stage 1 waits for mem_data; stage 2 registers the VGA outputs.
REQ-020 Total latency is 3 clk cycles from pixel_x/pixel_y to VGA_*, with hit and video_enable delayed along the same pipeline.
REQ-021 VGA_* SHALL be 0 when the delayed video_enable is 0 or no slot hit.
REQ-022 Addresses are derived purely from coordinates; there are no free-running sprite counters.
REQ-023 If two or more enabled slots hit on the same active pixel, their collision bits SHALL set and stay set until coll_clear; if a set and a clear coincide, the set wins.
REQ-024 mem_addr and mem_element SHALL hold 0 when there is no hit.

Reset
REQ-025 While reset=0, all slots SHALL be disabled (en=0, x=y=element=mirror=0), the pipeline valid bits cleared, VGA_*=0, mem_addr=0, mem_element=0 and collision=0.
REQ-026 Reset asserted mid-frame SHALL blank the output within 0 cycles (asynchronous); rendering resumes only after the next frame_sync following reset release.

Configuration
REQ-027 Macro SPRITE_MIRROR_EN: when defined, a slot with mirror=1 SHALL use dx' = SPRITE_SIZE-1-dx; when undefined, cfg_mirror is ignored, the mirror register is not implemented, and dx is used unchanged.

Structure
REQ-028 The package sprite_pkg holds SCREEN_W=800, SCREEN_H=600, the slot record typedef (x, y, element, en, mirror) and the colour-slice constants.
REQ-029 The sub-module sprite_hit_unit (one instance per slot: hit compare plus dx/dy) is natural; priority selection and the pipeline stay in the top.

Verification
REQ-030 Slot0 at (400,300), en=1, frame_sync, raster at (400,300) -> mem_addr=0 at +1 cycle; (431,331) -> mem_addr=1023; (432,300) -> no hit, VGA=0.
REQ-031 mem_data=12'hE52 on a hit pixel -> VGA_R=7, VGA_G=2, VGA_B=1 exactly 3 cycles after the coordinate.
REQ-032 Slots 0 and 1 overlapping at (100,100) -> fetch uses slot0's element; collision=4'b0011; coll_clear -> 0; a simultaneous hit and clear -> stays 0011.
REQ-033 cfg_we to slot2 mid-frame -> no visible change until frame_sync; cfg_we coinciding with frame_sync -> new value active immediately; cfg_sel=5 with N_SPRITES=4 -> ignored.
REQ-034 Slot at x=790 -> pixels 790..799 render and nothing wraps to x=0; with SPRITE_MIRROR_EN and mirror=1, pixel (x+0) -> mem_addr=31.
REQ-035 Reset pulsed mid-sprite -> VGA=0 immediately; after release, output stays 0 until frame_sync and reprogramming.
